// File: rtl/axi_fifo_skid.sv
// Two-entry AXI4-Stream register slice: output register plus skid register.
// Every output, including i_tready, comes straight from a flop.
module axi_fifo_skid #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic [1:0]       space,
    output logic [1:0]       occupied
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] odata_q, odata_d;
    logic [WIDTH-1:0] skid_q,  skid_d;
    logic             ovalid_q, ovalid_d;
    logic             iready_q, iready_d;
    logic [1:0]       occ_q,    occ_d;

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = i_tvalid & iready_q;
    assign out_xfer = ovalid_q & o_tready;

    always_comb begin
        state_d = state_q;
        odata_d = odata_q;
        skid_d  = skid_q;

        case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    state_d = ST_BUSY;
                    odata_d = i_tdata;
                end
            end
            ST_BUSY: begin
                if (in_xfer && out_xfer) begin
                    odata_d = i_tdata;
                end else if (in_xfer) begin
                    state_d = ST_FULL;
                    skid_d  = i_tdata;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // i_tready is low here, so only the drain side can move
                if (out_xfer) begin
                    state_d = ST_BUSY;
                    odata_d = skid_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        if (clear) begin
            state_d = ST_EMPTY;
        end

        ovalid_d = (state_d != ST_EMPTY);
        iready_d = (state_d != ST_FULL);

        case (state_d)
            ST_BUSY: occ_d = 2'd1;
            ST_FULL: occ_d = 2'd2;
            default: occ_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_EMPTY;
            odata_q  <= '0;
            skid_q   <= '0;
            ovalid_q <= 1'b0;
            iready_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            state_q  <= state_d;
            odata_q  <= odata_d;
            skid_q   <= skid_d;
            ovalid_q <= ovalid_d;
            iready_q <= iready_d;
            occ_q    <= occ_d;
        end
    end

    assign i_tready = iready_q;
    assign o_tdata  = odata_q;
    assign o_tvalid = ovalid_q;
    assign occupied = occ_q;
    assign space    = iready_q ? (2'd2 - occ_q) : 2'd0;

endmodule

// File: tb/tb_axi_fifo_skid.sv
// Bench for axi_fifo_skid: directed vector table, hand sequences for streaming
// and isolation of outputs from inputs, and a randomized run against a queue model.
module tb_axi_fifo_skid;

    localparam int WIDTH = 32;

    logic             clk;
    logic             reset_n;
    logic             clear;
    logic [WIDTH-1:0] i_tdata;
    logic             i_tvalid;
    logic             i_tready;
    logic [WIDTH-1:0] o_tdata;
    logic             o_tvalid;
    logic             o_tready;
    logic [1:0]       space;
    logic [1:0]       occupied;

    int ncmp = 0;
    int nbad = 0;

    axi_fifo_skid #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (clear),
        .i_tdata  (i_tdata),
        .i_tvalid (i_tvalid),
        .i_tready (i_tready),
        .o_tdata  (o_tdata),
        .o_tvalid (o_tvalid),
        .o_tready (o_tready),
        .space    (space),
        .occupied (occupied)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rn;
        logic        clr;
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_od;
        logic        chk_od;
        logic [1:0]  e_occ;
        logic [1:0]  e_sp;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic rn, input logic clr, input logic iv, input logic [31:0] d,
                       input logic ordy, input logic e_ir, input logic e_ov, input logic [31:0] e_od,
                       input logic chk_od, input logic [1:0] e_occ, input logic [1:0] e_sp);
        vec_t v;
        v.rn = rn; v.clr = clr; v.iv = iv; v.d = d; v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.chk_od = chk_od;
        v.e_occ = e_occ; v.e_sp = e_sp;
        vq.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rn, input logic clr, input logic iv,
                         input logic [31:0] d, input logic ordy);
        reset_n  = rn;
        clear    = clr;
        i_tvalid = iv;
        i_tdata  = d;
        o_tready = ordy;
    endtask

    // Random phase reference: a bounded FIFO of depth 2 plus a registered ready flag
    logic [31:0] mq[$];
    logic        m_ready;
    int          emitted;

    initial begin
        logic [31:0] od_snap;
        logic        hold_prev;
        logic [31:0] hold_data;
        logic        acc;
        logic        rn, clr, iv, ordy;
        logic [31:0] d;

        drive(1'b0, 1'b0, 1'b1, 32'h99, 1'b0);

        //   rn clr iv d        or  ir ov od       chk occ  sp
        add(0, 0, 1, 32'h99, 0,  0, 0, 32'h0,  1, 2'd0, 2'd0);
        add(0, 0, 1, 32'h99, 0,  0, 0, 32'h0,  1, 2'd0, 2'd0);
        add(0, 0, 1, 32'h99, 0,  0, 0, 32'h0,  1, 2'd0, 2'd0);
        add(1, 0, 0, 32'h0,  0,  1, 0, 32'h0,  1, 2'd0, 2'd2);
        add(1, 0, 1, 32'hA,  0,  1, 1, 32'hA,  1, 2'd1, 2'd1);
        add(1, 0, 1, 32'hB,  0,  0, 1, 32'hA,  1, 2'd2, 2'd0);
        add(1, 0, 1, 32'hC,  0,  0, 1, 32'hA,  1, 2'd2, 2'd0);
        add(1, 0, 0, 32'h0,  1,  1, 1, 32'hB,  1, 2'd1, 2'd1);
        add(1, 0, 0, 32'h0,  1,  1, 0, 32'h0,  0, 2'd0, 2'd2);
        add(1, 0, 1, 32'h5,  0,  1, 1, 32'h5,  1, 2'd1, 2'd1);
        add(1, 0, 1, 32'h6,  0,  0, 1, 32'h5,  1, 2'd2, 2'd0);
        add(1, 1, 0, 32'h0,  0,  1, 0, 32'h0,  0, 2'd0, 2'd2);
        add(1, 0, 1, 32'h7,  0,  1, 1, 32'h7,  1, 2'd1, 2'd1);
        add(1, 0, 0, 32'h0,  1,  1, 0, 32'h0,  0, 2'd0, 2'd2);
        add(1, 0, 1, 32'h8,  0,  1, 1, 32'h8,  1, 2'd1, 2'd1);
        add(1, 1, 1, 32'h9,  1,  1, 0, 32'h0,  0, 2'd0, 2'd2);
        add(1, 0, 0, 32'h0,  1,  1, 0, 32'h0,  0, 2'd0, 2'd2);
        add(1, 0, 1, 32'h11, 0,  1, 1, 32'h11, 1, 2'd1, 2'd1);
        add(0, 0, 1, 32'h12, 0,  0, 0, 32'h0,  1, 2'd0, 2'd0);
        add(1, 0, 1, 32'h13, 0,  1, 0, 32'h0,  1, 2'd0, 2'd2);
        add(1, 0, 1, 32'h14, 1,  1, 1, 32'h14, 1, 2'd1, 2'd1);
        add(1, 0, 0, 32'h0,  1,  1, 0, 32'h0,  0, 2'd0, 2'd2);
        add(0, 1, 1, 32'h15, 0,  0, 0, 32'h0,  1, 2'd0, 2'd0);
        add(1, 0, 0, 32'h0,  0,  1, 0, 32'h0,  1, 2'd0, 2'd2);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rn, vq[i].clr, vq[i].iv, vq[i].d, vq[i].ordy);
            tick();
            chk($sformatf("vec%0d_i_tready", i), 32'(i_tready), 32'(vq[i].e_ir));
            chk($sformatf("vec%0d_o_tvalid", i), 32'(o_tvalid), 32'(vq[i].e_ov));
            chk($sformatf("vec%0d_occupied", i), 32'(occupied), 32'(vq[i].e_occ));
            chk($sformatf("vec%0d_space", i), 32'(space), 32'(vq[i].e_sp));
            if (vq[i].chk_od)
                chk($sformatf("vec%0d_o_tdata", i), o_tdata, vq[i].e_od);
        end

        // Back-to-back streaming with the sink always ready
        for (int k = 1; k <= 16; k++) begin
            drive(1'b1, 1'b0, 1'b1, 32'(k), 1'b1);
            tick();
            chk($sformatf("stream%0d_o_tdata", k), o_tdata, 32'(k));
            chk($sformatf("stream%0d_o_tvalid", k), 32'(o_tvalid), 32'd1);
            chk($sformatf("stream%0d_occupied", k), 32'(occupied), 32'd1);
            chk($sformatf("stream%0d_i_tready", k), 32'(i_tready), 32'd1);
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        chk("stream_drain_o_tvalid", 32'(o_tvalid), 32'd0);

        // Mid-cycle input changes must not reach any output
        o_tready = 1'b1;
        #1;
        chk("iso_empty_i_tready", 32'(i_tready), 32'd1);
        i_tvalid = 1'b1;
        i_tdata  = 32'hDEAD;
        #1;
        chk("iso_empty_o_tvalid", 32'(o_tvalid), 32'd0);
        drive(1'b1, 1'b0, 1'b1, 32'h21, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 32'h22, 1'b0);
        tick();
        chk("iso_full_i_tready_before", 32'(i_tready), 32'd0);
        o_tready = 1'b1;
        #1;
        chk("iso_full_i_tready_after_oready", 32'(i_tready), 32'd0);
        i_tvalid = 1'b0;
        i_tdata  = 32'h3333;
        #1;
        chk("iso_full_o_tvalid", 32'(o_tvalid), 32'd1);
        chk("iso_full_o_tdata", o_tdata, 32'h21);
        i_tvalid = 1'b1;
        #1;
        chk("iso_full_o_tdata2", o_tdata, 32'h21);
        i_tvalid = 1'b0;
        tick();
        chk("iso_drain1_o_tdata", o_tdata, 32'h22);
        chk("iso_drain1_i_tready", 32'(i_tready), 32'd1);
        tick();
        chk("iso_drain2_o_tvalid", 32'(o_tvalid), 32'd0);

        // Randomized backpressure against the queue model
        mq.delete();
        m_ready   = 1'b0;
        emitted   = 0;
        hold_prev = 1'b0;
        hold_data = '0;
        for (int c = 0; c < 22000; c++) begin
            rn   = (c >= 2);
            clr  = ($urandom_range(0, 63) == 0);
            iv   = 1'($urandom_range(0, 1));
            ordy = 1'($urandom_range(0, 1));
            d    = $urandom;
            drive(rn, clr, iv, d, ordy);
            hold_prev = rn & ~clr & o_tvalid & ~o_tready;
            hold_data = o_tdata;
            acc = iv & m_ready;
            tick();

            if (!rn) begin
                mq.delete();
                m_ready = 1'b0;
            end else begin
                if (mq.size() > 0 && ordy) begin
                    void'(mq.pop_front());
                    emitted++;
                end
                if (clr) begin
                    mq.delete();
                    m_ready = 1'b1;
                end else begin
                    if (acc) mq.push_back(d);
                    m_ready = (mq.size() < 2);
                end
            end

            chk("rand_o_tvalid", 32'(o_tvalid), 32'(mq.size() > 0));
            chk("rand_i_tready", 32'(i_tready), 32'(m_ready));
            chk("rand_occupied", 32'(occupied), 32'(mq.size()));
            chk("rand_space", 32'(space), m_ready ? 32'(2 - mq.size()) : 32'd0);
            if (mq.size() > 0) begin
                od_snap = mq[0];
                chk("rand_order_o_tdata", o_tdata, od_snap);
            end
            if (hold_prev) begin
                chk("rand_hold_o_tvalid", 32'(o_tvalid), 32'd1);
                chk("rand_hold_o_tdata", o_tdata, hold_data);
            end
        end
        chk("rand_emitted_enough", 32'(emitted >= 3000), 32'd1);

        $display("test done: total=%0d bad=%0d", ncmp, nbad);
        $finish;
    end

endmodule
